// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display fetches win over CPU accesses, except when a CPU
// request has lost CPU_MAX_WAIT cycles in a row, in which case it takes one forced slot.
module vram_port_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 8,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              disp_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    // Tag carried with every read so the returning byte reaches the right requester.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    logic              disp_pend;
    logic [ADDR_W-1:0] pend_addr;
    logic              cpu_busy;
    logic [WAIT_W-1:0] wait_cnt;
    owner_t            owner_s1;
    owner_t            owner_s2;
    logic              wr_s1;

    logic              cpu_elig;
    logic              disp_any;
    logic [ADDR_W-1:0] disp_sel_addr;
    logic              cpu_force;
    logic              grant_cpu;
    logic              grant_disp;
    logic              cpu_done;

    always_comb begin
        cpu_elig      = cpu_req && !cpu_busy;
        disp_any      = disp_pend || disp_req;
        disp_sel_addr = disp_req ? disp_addr : pend_addr;
        cpu_force     = cpu_elig && (wait_cnt == WAIT_MAX);
        grant_cpu     = cpu_force || (cpu_elig && !disp_any);
        grant_disp    = disp_any && !cpu_force;
        cpu_done      = wr_s1 || (owner_s2 == OWN_CPU);
    end

    // RAM command register: idle cycles hold the address and deassert write enable.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            ram_we <= 1'b0;
            if (grant_disp) begin
                ram_addr <= disp_sel_addr;
            end else if (grant_cpu) begin
                ram_addr <= cpu_addr;
                ram_we   <= cpu_we;
                if (cpu_we) begin
                    ram_wdata <= cpu_wdata;
                end
            end
        end
    end

    // A newer request while one is still waiting replaces it and flags the overrun.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            disp_pend    <= 1'b0;
            pend_addr    <= '0;
            disp_overrun <= 1'b0;
        end else begin
            if (grant_disp) begin
                disp_pend <= 1'b0;
            end else if (disp_req) begin
                disp_pend <= 1'b1;
                pend_addr <= disp_addr;
            end
            if (disp_req && disp_pend) begin
                disp_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            cpu_busy <= 1'b0;
        end else begin
            if (!cpu_elig || grant_cpu) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (grant_cpu) begin
                cpu_busy <= 1'b1;
            end else if (cpu_done) begin
                cpu_busy <= 1'b0;
            end
        end
    end

    // Reads return two edges after the grant; writes are acknowledged one edge after.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            owner_s1   <= OWN_NONE;
            owner_s2   <= OWN_NONE;
            wr_s1      <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            if (grant_disp) begin
                owner_s1 <= OWN_DISP;
            end else if (grant_cpu && !cpu_we) begin
                owner_s1 <= OWN_CPU;
            end else begin
                owner_s1 <= OWN_NONE;
            end
            wr_s1      <= grant_cpu && cpu_we;
            owner_s2   <= owner_s1;
            disp_valid <= (owner_s2 == OWN_DISP);
            if (owner_s2 == OWN_DISP) begin
                disp_data <= ram_rdata;
            end
            cpu_ack <= cpu_done;
            if (owner_s2 == OWN_CPU) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural synchronous 8K x 8 RAM.
module tb_vram_port_arbiter;

    logic        clk_pixel;
    logic        reset;
    logic        disp_req;
    logic [12:0] disp_addr;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_overrun;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:8191];
    int          checks = 0;
    int          errors = 0;

    vram_port_arbiter #(
        .ADDR_W(13),
        .DATA_W(8),
        .CPU_MAX_WAIT(4)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .disp_req(disp_req),
        .disp_addr(disp_addr),
        .disp_data(disp_data),
        .disp_valid(disp_valid),
        .disp_overrun(disp_overrun),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Clock / reset
    initial begin
        clk_pixel = 1'b0;
        forever #5 clk_pixel = ~clk_pixel;
    end

    function automatic logic [7:0] preload(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]};
    endfunction

    // RAM model: samples address/write at the edge, read data available the cycle after
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = preload(13'(i));
        ram_rdata = 8'h00;
        forever begin
            @(posedge clk_pixel);
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        disp_req  = 1'b0;
        disp_addr = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        disp_req  = 1'b0;
        disp_addr = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        #2;
        checks++;
        if (ram_addr !== 13'h0 || ram_we !== 1'b0 || ram_wdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_ram got addr=%h we=%b wd=%h exp 0/0/0", ram_addr, ram_we, ram_wdata);
        end
        checks++;
        if (disp_valid !== 1'b0 || disp_data !== 8'h0 || disp_overrun !== 1'b0 ||
            cpu_ack !== 1'b0 || cpu_rdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_out got dv=%b dd=%h ov=%b ack=%b rd=%h exp all 0",
                     disp_valid, disp_data, disp_overrun, cpu_ack, cpu_rdata);
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_display_only();
        for (int i = 0; i < 32; i++) begin
            disp_req  = 1'b1;
            disp_addr = 13'(i);
            tick();
            disp_req = 1'b0;
            tick();
            checks++;
            if (disp_valid !== 1'b0) begin
                errors++;
                $display("FAIL disp_early addr=%0h got=%b exp=0", i, disp_valid);
            end
            tick();
            checks++;
            if (disp_valid !== 1'b1 || disp_data !== 8'(i)) begin
                errors++;
                $display("FAIL disp_data addr=%0h got v=%b d=%h exp v=1 d=%h", i, disp_valid, disp_data, 8'(i));
            end
            for (int j = 0; j < 5; j++) tick();
        end
        checks++;
        if (disp_overrun !== 1'b0) begin
            errors++;
            $display("FAIL disp_only_overrun got=%b exp=0", disp_overrun);
        end
    endtask

    task automatic test_cpu_write_read();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 13'h1234;
        cpu_wdata = 8'hA5;
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 13'h1234 || ram_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL wr_grant got ack=%b we=%b a=%h wd=%h exp 0/1/1234/a5", cpu_ack, ram_we, ram_addr, ram_wdata);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack got ack=%b we=%b exp ack=1 we=0", cpu_ack, ram_we);
        end
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 13'h1234) begin
            errors++;
            $display("FAIL rd_grant got ack=%b we=%b a=%h exp 0/0/1234", cpu_ack, ram_we, ram_addr);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL rd_early got=%b exp=0", cpu_ack);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rd_ack got ack=%b d=%h exp ack=1 d=a5", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_collision();
        disp_req  = 1'b1;
        disp_addr = 13'h0100;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 13'h0200;
        tick();
        disp_req = 1'b0;
        checks++;
        if (ram_addr !== 13'h0100) begin
            errors++;
            $display("FAIL coll_first got=%h exp=0100", ram_addr);
        end
        tick();
        checks++;
        if (ram_addr !== 13'h0200) begin
            errors++;
            $display("FAIL coll_second got=%h exp=0200", ram_addr);
        end
        tick();
        checks++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h01 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL coll_disp got v=%b d=%h ack=%b exp v=1 d=01 ack=0", disp_valid, disp_data, cpu_ack);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h02 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL coll_cpu got ack=%b d=%h v=%b exp ack=1 d=02 v=0", cpu_ack, cpu_rdata, disp_valid);
        end
        cpu_req = 1'b0;
        tick();
        tick();
    endtask

    // CPU write held pending while display requests every cycle for 12 cycles
    task automatic test_starvation();
        logic [7:0] exp_q[$];
        logic [7:0] exp;
        int         vcount = 0;
        apply_reset();
        for (int n = 1; n <= 12; n++) if (n != 5) exp_q.push_back(8'(8'h20 + n));
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 13'h0040;
        cpu_wdata = 8'h5A;
        for (int n = 1; n <= 16; n++) begin
            disp_req  = (n <= 12);
            disp_addr = 13'(13'h20 + n);
            tick();
            if (n == 5) begin
                checks++;
                if (ram_we !== 1'b1 || ram_addr !== 13'h0040 || ram_wdata !== 8'h5A) begin
                    errors++;
                    $display("FAIL starve_forced got we=%b a=%h wd=%h exp 1/0040/5a", ram_we, ram_addr, ram_wdata);
                end
            end
            checks++;
            if (cpu_ack !== 1'(n == 6)) begin
                errors++;
                $display("FAIL starve_ack cycle=%0d got=%b exp=%b", n, cpu_ack, (n == 6));
            end
            if (n == 6) cpu_req = 1'b0;
            if (disp_valid === 1'b1) begin
                vcount++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL starve_extra cycle=%0d got d=%h exp no valid", n, disp_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (disp_data !== exp) begin
                        errors++;
                        $display("FAIL starve_data cycle=%0d got=%h exp=%h", n, disp_data, exp);
                    end
                end
            end
        end
        disp_req = 1'b0;
        checks++;
        if (vcount != 11 || disp_overrun !== 1'b1) begin
            errors++;
            $display("FAIL starve_end got valids=%0d ov=%b exp valids=11 ov=1", vcount, disp_overrun);
        end
    endtask

    // Request at 0x0010 lands on the forced CPU slot, then 0x0011 replaces it
    task automatic test_overrun();
        logic [7:0] exp_q[$];
        logic [7:0] exp;
        int         vcount = 0;
        apply_reset();
        exp_q = '{8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h11};
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 13'h0050;
        cpu_wdata = 8'h77;
        for (int n = 1; n <= 10; n++) begin
            disp_req  = (n <= 6);
            disp_addr = 13'(13'h0B + n);
            tick();
            if (n == 5 || n == 6) begin
                checks++;
                if (disp_overrun !== 1'(n == 6)) begin
                    errors++;
                    $display("FAIL ovr_flag cycle=%0d got=%b exp=%b", n, disp_overrun, (n == 6));
                end
            end
            if (n == 6) begin
                checks++;
                if (cpu_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_cpu_ack got=%b exp=1", cpu_ack);
                end
                cpu_req = 1'b0;
            end
            if (disp_valid === 1'b1) begin
                vcount++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ovr_extra cycle=%0d got d=%h exp no valid", n, disp_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (disp_data !== exp) begin
                        errors++;
                        $display("FAIL ovr_data cycle=%0d got=%h exp=%h", n, disp_data, exp);
                    end
                end
            end
        end
        disp_req = 1'b0;
        checks++;
        if (vcount != 5 || disp_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_end got valids=%0d ov=%b exp valids=5 ov=1", vcount, disp_overrun);
        end
    endtask

    task automatic test_reset_inflight();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0300;
        tick();
        tick();
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        checks++;
        if (ram_addr !== 13'h0 || ram_we !== 1'b0 || ram_wdata !== 8'h0 || cpu_ack !== 1'b0 ||
            cpu_rdata !== 8'h0 || disp_valid !== 1'b0 || disp_data !== 8'h0 || disp_overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got a=%h we=%b wd=%h ack=%b rd=%h dv=%b dd=%h ov=%b exp all 0",
                     ram_addr, ram_we, ram_wdata, cpu_ack, cpu_rdata, disp_valid, disp_data, disp_overrun);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cpu_ack !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale_ack cycle=%0d got=%b exp=0", i, cpu_ack);
            end
        end
        cpu_req = 1'b1;
        tick();
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_new_early got=%b exp=0", cpu_ack);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h03) begin
            errors++;
            $display("FAIL rst_new_read got ack=%b d=%h exp ack=1 d=03", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_display_only();
        test_cpu_write_read();
        test_collision();
        test_starvation();
        test_overrun();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
